// File: rtl/pdm_cic_decimator.sv
// rtl/pdm_cic_decimator.sv - third-order CIC decimator, 1-bit PDM to signed OUT_W-bit PCM at clk/DECIM
// Optional macro PDM_SYNC_EN inserts a 2-flop synchronizer on pdm (adds 2 clks of latency).
module pdm_cic_decimator #(
  parameter int DECIM = 1024,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    pdm,
  output logic signed [OUT_W-1:0] smp,
  output logic                    smp_vld,
  output logic                    sat,
  output logic                    settled
);
  localparam int L     = $clog2(DECIM);
  localparam int ACC_W = 3*L + 2;
  localparam int SHIFT = 3*L + 1 - OUT_W;
  localparam logic [L-1:0] CNT_MAX = L'(DECIM - 1);
  localparam logic signed [ACC_W-1:0] MAX_POS = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);

  logic pdm_bit;

`ifdef PDM_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], pdm};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign pdm_bit = sync_q[1];
`else
  assign pdm_bit = pdm;
`endif

  logic signed [ACC_W-1:0] x_in;
  logic signed [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic signed [ACC_W-1:0] d_q, d_d, dly1_q, dly1_d;
  logic signed [ACC_W-1:0] c1_q, c1_d, dly2_q, dly2_d;
  logic signed [ACC_W-1:0] c2_q, c2_d, dly3_q, dly3_d;
  logic signed [ACC_W-1:0] c3_q, c3_d;
  logic signed [ACC_W-1:0] shifted;
  logic [L-1:0]            cnt_q, cnt_d;
  logic [3:0]              stg_q, stg_d;
  logic signed [OUT_W-1:0] smp_q, smp_d;
  logic                    smp_vld_q, smp_vld_d;
  logic                    sat_q, sat_d;
  logic [1:0]              pcnt_q, pcnt_d;
  logic                    settled_q, settled_d;
  logic                    clip;

  assign x_in    = pdm_bit ? ACC_W'(1) : '1;
  assign shifted = c3_q >>> SHIFT;
  assign clip    = shifted > MAX_POS;

  // stg_q[k] marks which comb stage holds the frame in flight; everything freezes with en=0
  always_comb begin
    i1_d      = i1_q;
    i2_d      = i2_q;
    i3_d      = i3_q;
    cnt_d     = cnt_q;
    d_d       = d_q;
    dly1_d    = dly1_q;
    c1_d      = c1_q;
    dly2_d    = dly2_q;
    c2_d      = c2_q;
    dly3_d    = dly3_q;
    c3_d      = c3_q;
    stg_d     = stg_q;
    smp_d     = smp_q;
    smp_vld_d = 1'b0;
    sat_d     = 1'b0;
    pcnt_d    = pcnt_q;
    settled_d = settled_q;
    if (en) begin
      i1_d  = i1_q + x_in;
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      cnt_d = cnt_q + L'(1);
      stg_d = {stg_q[2:0], 1'b0};
      if (stg_q[0]) begin
        c1_d   = d_q - dly1_q;
        dly1_d = d_q;
      end
      if (stg_q[1]) begin
        c2_d   = c1_q - dly2_q;
        dly2_d = c1_q;
      end
      if (stg_q[2]) begin
        c3_d   = c2_q - dly3_q;
        dly3_d = c2_q;
      end
      if (stg_q[3]) begin
        smp_d     = clip ? MAX_POS[OUT_W-1:0] : shifted[OUT_W-1:0];
        sat_d     = clip;
        smp_vld_d = 1'b1;
        if (!settled_q) begin
          if (pcnt_q == 2'd2) settled_d = 1'b1;
          else                pcnt_d    = pcnt_q + 2'd1;
        end
      end
      if (cnt_q == CNT_MAX) begin
        d_d      = i3_q;
        stg_d[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q      <= '0;
      i2_q      <= '0;
      i3_q      <= '0;
      cnt_q     <= '0;
      d_q       <= '0;
      dly1_q    <= '0;
      c1_q      <= '0;
      dly2_q    <= '0;
      c2_q      <= '0;
      dly3_q    <= '0;
      c3_q      <= '0;
      stg_q     <= '0;
      smp_q     <= '0;
      smp_vld_q <= 1'b0;
      sat_q     <= 1'b0;
      pcnt_q    <= '0;
      settled_q <= 1'b0;
    end else begin
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      i3_q      <= i3_d;
      cnt_q     <= cnt_d;
      d_q       <= d_d;
      dly1_q    <= dly1_d;
      c1_q      <= c1_d;
      dly2_q    <= dly2_d;
      c2_q      <= c2_d;
      dly3_q    <= dly3_d;
      c3_q      <= c3_d;
      stg_q     <= stg_d;
      smp_q     <= smp_d;
      smp_vld_q <= smp_vld_d;
      sat_q     <= sat_d;
      pcnt_q    <= pcnt_d;
      settled_q <= settled_d;
    end
  end

  assign smp     = smp_q;
  assign smp_vld = smp_vld_q;
  assign sat     = sat_q;
  assign settled = settled_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb/tb_pdm_cic_decimator.sv - self-checking bench for pdm_cic_decimator
// Expected samples are queued at each frame boundary and matched against smp_vld pulses.
module tb_pdm_cic_decimator;
  localparam int DECIM = 1024;
  localparam int OUT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic pdm = 1'b0;
  logic signed [OUT_W-1:0] smp;
  logic smp_vld, sat, settled;

  pdm_cic_decimator #(.DECIM(DECIM), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pdm(pdm),
    .smp(smp), .smp_vld(smp_vld), .sat(sat), .settled(settled)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int smp;
    int tol;
    bit sat;
    bit chk;
    bit settled;
  } exp_t;

  typedef struct {
    logic [3:0] pat;
    int         plen;
    int         smp;
    int         tol;
    bit         sat;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int n_vec = 0;
  int n_err = 0;
  int rc = 0;
  int ph = 0;
  int plen = 1;
  logic [3:0] pat = 4'b0001;
  int cur_smp = 0;
  int cur_tol = 0;
  bit cur_sat = 1'b0;

  task automatic check(input string name, input longint act, input longint exp, input longint tol);
    n_vec++;
    if (act < exp - tol || act > exp + tol) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (tol %0d) at run edge %0d", name, act, exp, tol, rc);
    end
  endtask

  // one clock with the current pattern; rc counts edges on which the DUT runs
  task automatic step();
    exp_t e;
    pdm = pat[ph];
    @(posedge clk);
    #1;
    if (rst_n && en) begin
      rc++;
      ph = (ph + 1) % plen;
      if (rc % DECIM == 0) begin
        e.due     = rc + 4;
        e.smp     = cur_smp;
        e.tol     = cur_tol;
        e.sat     = cur_sat;
        e.chk     = (rc / DECIM) >= 4;
        e.settled = (rc / DECIM) >= 3;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sbq.delete();
    rc = 0;
    ph = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic pause(input int n);
    en = 1'b0;
    for (int i = 0; i < n; i++) begin
      pdm = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("vld_during_pause", smp_vld, 0, 0);
    end
    en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (smp_vld) begin
      if (sbq.size() == 0) begin
        check("unexpected_vld", smp_vld, 0, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("vld_time", rc, mon_e.due, 0);
        check("settled", settled, mon_e.settled, 0);
        if (mon_e.chk) begin
          check("smp", smp, mon_e.smp, mon_e.tol);
          check("sat", sat, mon_e.sat, 0);
        end
      end
    end else if (sbq.size() > 0 && rc > sbq[0].due) begin
      mon_e = sbq.pop_front();
      check("missing_vld_due", rc, mon_e.due, 0);
    end
  end

  initial begin
    vec_t tbl[4];
    logic signed [OUT_W-1:0] smp_before;

    tbl[0] = '{pat: 4'b0001, plen: 1, smp:  32767, tol: 0, sat: 1'b1};
    tbl[1] = '{pat: 4'b0000, plen: 1, smp: -32768, tol: 0, sat: 1'b0};
    tbl[2] = '{pat: 4'b0001, plen: 2, smp:      0, tol: 0, sat: 1'b0};
    tbl[3] = '{pat: 4'b0111, plen: 4, smp:  16384, tol: 1, sat: 1'b0};

    #1;
    check("rst_smp", smp, 0, 0);
    check("rst_vld", smp_vld, 0, 0);
    check("rst_sat", sat, 0, 0);
    check("rst_settled", settled, 0, 0);
    en = 1'b1;

    for (int i = 0; i < 4; i++) begin
      pat     = tbl[i].pat;
      plen    = tbl[i].plen;
      cur_smp = tbl[i].smp;
      cur_tol = tbl[i].tol;
      cur_sat = tbl[i].sat;
      do_reset();
      repeat (5*DECIM + 8) step();
      check("drain", sbq.size(), 0, 0);
    end

    // long pause mid-frame, then a short pause with the comb pipe half full
    pat = 4'b0001; plen = 1; cur_smp = 32767; cur_tol = 0; cur_sat = 1'b1;
    do_reset();
    repeat (4*DECIM + 200) step();
    smp_before = smp;
    pause(300);
    check("smp_hold", smp, smp_before, 0);
    while (rc < 5*DECIM + 2) step();
    pause(7);
    while (rc < 6*DECIM + 8) step();
    check("pause_drain", sbq.size(), 0, 0);

    // async reset two clocks after a wrap, while the comb pipe is busy
    do_reset();
    while (rc < 4*DECIM + 2) step();
    #1;
    rst_n = 1'b0;
    sbq.delete();
    rc = 0;
    ph = 0;
    #1;
    check("abort_smp", smp, 0, 0);
    check("abort_vld", smp_vld, 0, 0);
    check("abort_sat", sat, 0, 0);
    check("abort_settled", settled, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4*DECIM + 8) step();
    check("abort_drain", sbq.size(), 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
